qspi_fifo_tx: RTL and testbench
===============================

# qspi_fifo_tx

Read-path transmitter for the QSPI bridge. It drains 32-bit words from an `fsfifo` read port and presents them as a nibble stream on the QSPI IO lines. A fixed dummy phase precedes the data, and a one-word prefetch stage hides the FIFO's one-cycle read latency. It sits between the response FIFO and the IO pad muxing, and advances on SCK-edge strobes produced by the QSPI front end.

## Interface
Parameters:
- `WIDTH`, 32: FIFO word width. Must be a multiple of 4.
- `DUMMY`, 8: dummy SCK edges before data. Legal range 1..255.

Ports:
- `clk_i` in 1: the single clock. All logic is `posedge`.
- `resetn_i` in 1: synchronous, active-low reset.
- `cs_i` in 1: chip select, active-high, already synchronized.
- `start_i` in 1: one-cycle strobe that begins a read transfer.
- `shift_i` in 1: one-cycle strobe per SCK output edge. The host has sampled the current nibble.
- `fifo_empty_i` in 1: FIFO `empty_o`.
- `fifo_rd_o` out 1: FIFO `rd_i`.
- `fifo_data_i` in WIDTH: FIFO `rd_data_o`. Valid the cycle after `fifo_rd_o`.
- `io_o` out 4: data nibble.
- `io_oe_o` out 1: IO output enable.
- `busy_o` out 1: high in any state except IDLE.
- `underrun_o` out 1: sticky underrun flag.

## Operation
States:
- **IDLE**
  - `io_oe_o`=0.
  - On `start_i && cs_i`: load dummy counter with `DUMMY`, clear `underrun_o`, go to DUMMY.
  - `start_i` is ignored in every other state.
- **DUMMY**
  - `io_oe_o`=0.
  - Each `shift_i` decrements the counter.
  - On the `shift_i` that takes the counter 1→0: go to SHIFT and load the shift register.
- **SHIFT**
  - `io_oe_o`=1. `io_o` = `shreg[WIDTH-1:WIDTH-4]` (MSB nibble first).
  - On `shift_i` when the nibble counter is below `WIDTH/4-1`: shift `shreg` left by 4 and increment the counter.
  - On `shift_i` at the last nibble: reload `shreg` and reset the counter to 0.
- **Any state**
  - `!cs_i` → IDLE on the next edge.
  - The partially shifted word is discarded.
  - `cs_i` drop takes priority over a simultaneous `shift_i` or `start_i`.

Shift register reload:
- If `next_valid`: load `next_q` and clear `next_valid`.
- Otherwise it is an underrun: load all-ones (nibble `4'hF` repeated) and set `underrun_o`.

Prefetch stage (`next_q`, `next_valid`, `inflight`):
- `fifo_rd_o = busy_o && !next_valid && !inflight && !fifo_empty_i`. Combinational.
- The cycle after `fifo_rd_o`: `inflight`=1.
- The cycle after that: `next_q` ← `fifo_data_i`, `next_valid`=1, `inflight`=0.
- `next_q`, `next_valid` and an in-flight read survive return to IDLE. No FIFO word is lost except the one partially shifted at `cs_i` drop.
- In IDLE, no new read is issued.

Arithmetic:
- Nibble counter is `$clog2(WIDTH/4)` bits.
- Dummy counter is 8 bits.

## Timing
- Reset values: `io_o`=0, `io_oe_o`=0, `fifo_rd_o`=0, `busy_o`=0, `underrun_o`=0, `next_valid`=0, `inflight`=0, state=IDLE.
- `io_o` and `io_oe_o` are registered outputs. They change the cycle after the causing `shift_i`.
- Prefetch latency: `fifo_rd_o` at cycle N → `next_valid` visible at N+2.
  - No underrun on the first word, provided `fifo_empty_i`=0 at start and at least 2 clocks elapse before the final dummy `shift_i`.
  - Steady state: one word fetched per WIDTH/4 `shift_i`. No underrun if consecutive `shift_i` are ≥1 clock apart and the FIFO is non-empty.
- `shift_i` in IDLE is ignored.
- Back-to-back `shift_i` on consecutive cycles is legal.

## Configuration
- Macro: `QSPI_TX_UNDERRUN_EN`.
- **Defined:** `underrun_o` behaves as above. It is sticky until the next accepted `start_i` or reset.
- **Undefined:**
  - `underrun_o` is tied to 0.
  - The all-ones fill is still transmitted on underrun.
  - No flag register is synthesized.

## Structure
- Shared package `qspi_pkg`:
  - State enum (IDLE, DUMMY, SHIFT).
  - `QSPI_NIBBLE` = 4.
  - Underrun fill nibble `4'hF`.
- One natural sub-module, `qspi_tx_prefetch`:
  - Holds `next_q`, `next_valid` and `inflight`, and generates `fifo_rd_o`.
  - Exposes `take_i`, `valid_o` and `data_o` to the FSM.
- `fsfifo` is instantiated by the parent, not inside this block.

## Test plan
- **Reset:** hold `resetn_i`=0 for 3 cycles with `start_i`=1 and `shift_i`=1 → all outputs 0 and `fifo_rd_o`=0 throughout.
- **Basic read:**
  - Stimulus: FIFO preloaded with `32'h12345678` and `32'h9ABCDEF0`; `start_i`; 8 dummy `shift_i` spaced 2 clocks apart.
  - Response: `io_o` sequence 1,2,…,8 then 9,A,…,0; `io_oe_o`=1 only after the 8th dummy strobe; `underrun_o`=0.
- **Underrun:**
  - Stimulus: FIFO holding one word `32'hA5A5A5A5`; 16 data `shift_i`.
  - Response: A,5,…,A,5, then eight `4'hF` nibbles; `underrun_o`=1 from the 9th data strobe. Next `start_i` clears it.
- **CS abort:** drop `cs_i` after 3 nibbles of `32'h11223344` with the next word prefetched → IDLE next cycle, `io_oe_o`=0. A new transfer starts with the prefetched word, not 44.
- **Simultaneous:** `shift_i` and `!cs_i` in the same cycle → no shift, state IDLE. `start_i` while in SHIFT → ignored, stream uninterrupted.
- **Config:** with `QSPI_TX_UNDERRUN_EN` undefined, repeat the underrun scenario → `underrun_o` stays 0, data identical.

Source files
------------

// File: rtl/qspi_pkg.sv
// Shared definitions for the QSPI bridge transmit path: FSM states, nibble width, underrun fill.
package qspi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DUMMY = 2'd1,
    ST_SHIFT = 2'd2
  } qspi_state_e;

  localparam int unsigned QSPI_NIBBLE = 4;
  localparam logic [3:0]  QSPI_FILL   = 4'hF;

endpackage

// File: rtl/qspi_tx_prefetch.sv
// One-word prefetch stage in front of the fsfifo read port; hides the FIFO's one-cycle read latency.
module qspi_tx_prefetch
  import qspi_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             busy_i,
  input  logic             take_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] next_q, next_d;

  assign fifo_rd_o = busy_i && !valid_q && !inflight_q && !fifo_empty_i;
  assign valid_o   = valid_q;
  assign data_o    = next_q;

  // An in-flight read always completes, even after the FSM has gone idle.
  always_comb begin
    valid_d    = valid_q;
    inflight_d = inflight_q;
    next_d     = next_q;
    if (inflight_q) begin
      next_d     = fifo_data_i;
      valid_d    = 1'b1;
      inflight_d = 1'b0;
    end else if (fifo_rd_o) begin
      inflight_d = 1'b1;
    end
    if (take_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      valid_q    <= 1'b0;
      inflight_q <= 1'b0;
      next_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      inflight_q <= inflight_d;
      next_q     <= next_d;
    end
  end

endmodule

// File: rtl/qspi_fifo_tx.sv
// QSPI read-path transmitter: dummy phase, then FIFO words as MSB-first nibbles on SCK strobes.
// Optional sticky underrun flag is built only when QSPI_TX_UNDERRUN_EN is defined.
module qspi_fifo_tx
  import qspi_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DUMMY = 8
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             cs_i,
  input  logic             start_i,
  input  logic             shift_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic [3:0]       io_o,
  output logic             io_oe_o,
  output logic             busy_o,
  output logic             underrun_o
);

  localparam int unsigned     NIBBLES   = WIDTH / QSPI_NIBBLE;
  localparam int unsigned     NCW       = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [NCW-1:0]  NLAST     = NCW'(NIBBLES - 1);
  localparam logic [WIDTH-1:0] FILL_WORD = {NIBBLES{QSPI_FILL}};

  qspi_state_e      state_q, state_d;
  logic [7:0]       dcnt_q, dcnt_d;
  logic [NCW-1:0]   ncnt_q, ncnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [3:0]       io_q, io_d;
  logic             oe_q, oe_d;
  logic             reload;
  logic             take;
  logic             pf_valid;
  logic [WIDTH-1:0] pf_data;

  assign busy_o  = (state_q != ST_IDLE);
  assign io_o    = io_q;
  assign io_oe_o = oe_q;

  qspi_tx_prefetch #(
    .WIDTH(WIDTH)
  ) u_prefetch (
    .clk_i       (clk_i),
    .resetn_i    (resetn_i),
    .busy_i      (busy_o),
    .take_i      (take),
    .fifo_empty_i(fifo_empty_i),
    .fifo_rd_o   (fifo_rd_o),
    .fifo_data_i (fifo_data_i),
    .valid_o     (pf_valid),
    .data_o      (pf_data)
  );

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    ncnt_d  = ncnt_q;
    shreg_d = shreg_q;
    reload  = 1'b0;
    if (!cs_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_DUMMY;
            dcnt_d  = 8'(DUMMY);
          end
        end
        ST_DUMMY: begin
          if (shift_i) begin
            dcnt_d = dcnt_q - 8'd1;
            if (dcnt_q == 8'd1) begin
              state_d = ST_SHIFT;
              ncnt_d  = '0;
              reload  = 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          if (shift_i) begin
            if (ncnt_q == NLAST) begin
              ncnt_d = '0;
              reload = 1'b1;
            end else begin
              shreg_d = shreg_q << QSPI_NIBBLE;
              ncnt_d  = ncnt_q + NCW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    take = reload && pf_valid;
    if (reload) begin
      shreg_d = pf_valid ? pf_data : FILL_WORD;
    end
    // Outputs are registered from next-state values so they move one cycle after the strobe.
    oe_d = (state_d == ST_SHIFT);
    io_d = oe_d ? shreg_d[WIDTH-1 -: 4] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      ncnt_q  <= '0;
      shreg_q <= '0;
      io_q    <= '0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      ncnt_q  <= ncnt_d;
      shreg_q <= shreg_d;
      io_q    <= io_d;
      oe_q    <= oe_d;
    end
  end

`ifdef QSPI_TX_UNDERRUN_EN
  logic underrun_q, underrun_d;
  logic start_acc;

  assign start_acc  = (state_q == ST_IDLE) && cs_i && start_i;
  assign underrun_o = underrun_q;

  always_comb begin
    underrun_d = underrun_q;
    if (start_acc) begin
      underrun_d = 1'b0;
    end
    if (reload && !pf_valid) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end
`else
  assign underrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_qspi_fifo_tx.sv
// Directed self-checking bench for qspi_fifo_tx with a small behavioural fsfifo read port.
module tb_qspi_fifo_tx;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cs;
  logic        start;
  logic        shift;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [31:0] fifo_data = '0;
  logic [3:0]  io;
  logic        io_oe;
  logic        busy;
  logic        underrun;

  int unsigned n_asserts = 0;
  int unsigned n_fail    = 0;

`ifdef QSPI_TX_UNDERRUN_EN
  localparam bit UR_EN = 1'b1;
`else
  localparam bit UR_EN = 1'b0;
`endif

  logic [31:0] mem [0:15];
  int unsigned wp = 0;
  int unsigned rp = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_data <= mem[rp[3:0]];
      rp <= rp + 1;
    end
  end

  qspi_fifo_tx #(
    .WIDTH(32),
    .DUMMY(8)
  ) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .cs_i        (cs),
    .start_i     (start),
    .shift_i     (shift),
    .fifo_empty_i(fifo_empty),
    .fifo_rd_o   (fifo_rd),
    .fifo_data_i (fifo_data),
    .io_o        (io),
    .io_oe_o     (io_oe),
    .busy_o      (busy),
    .underrun_o  (underrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wp[3:0]] = w;
    wp = wp + 1;
  endtask

  task automatic shift_pulse();
    shift = 1'b1;
    step();
    shift = 1'b0;
  endtask

  task automatic begin_xfer(input logic exp_rd);
    cs    = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_rd", 32'(fifo_rd), 32'(exp_rd));
  endtask

  // Eight dummy strobes two clocks apart; output enable must rise only on the last one.
  task automatic dummy_phase();
    for (int i = 0; i < 8; i++) begin
      shift_pulse();
      check("dummy_oe", 32'(io_oe), (i == 7) ? 32'd1 : 32'd0);
      step();
    end
  endtask

  task automatic drop_cs();
    cs = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_oe", 32'(io_oe), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w1, w2, w3;
    logic [3:0]  exp_nib;

    resetn = 1'b0;
    cs     = 1'b1;
    start  = 1'b1;
    shift  = 1'b1;
    push(32'h12345678);
    push(32'h9ABCDEF0);

    // Reset with strobes active
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_io", 32'(io), 32'd0);
      check("rst_oe", 32'(io_oe), 32'd0);
      check("rst_rd", 32'(fifo_rd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_underrun", 32'(underrun), 32'd0);
    end
    resetn = 1'b1;
    start  = 1'b0;
    shift  = 1'b0;
    step();
    check("post_rst_busy", 32'(busy), 32'd0);

    // Basic read of two words
    w1 = 32'h12345678;
    w2 = 32'h9ABCDEF0;
    begin_xfer(1'b1);
    dummy_phase();
    check("basic_first", 32'(io), 32'h1);
    for (int k = 1; k < 16; k++) begin
      shift_pulse();
      exp_nib = (k < 8) ? w1[31-4*k -: 4] : w2[31-4*(k-8) -: 4];
      check("basic_nib", 32'(io), 32'(exp_nib));
      check("basic_oe", 32'(io_oe), 32'd1);
    end
    check("basic_underrun", 32'(underrun), 32'd0);
    drop_cs();

    // Underrun after a single word
    w3 = 32'hA5A5A5A5;
    push(w3);
    begin_xfer(1'b1);
    dummy_phase();
    check("ur_first", 32'(io), 32'hA);
    check("ur_flag_init", 32'(underrun), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      shift_pulse();
      exp_nib = (k < 8) ? w3[31-4*k -: 4] : 4'hF;
      check("ur_nib", 32'(io), 32'(exp_nib));
      check("ur_flag", 32'(underrun), 32'(UR_EN && (k >= 8)));
    end
    drop_cs();
    check("ur_sticky", 32'(underrun), 32'(UR_EN));
    begin_xfer(1'b0);
    check("ur_cleared", 32'(underrun), 32'd0);
    drop_cs();

    // CS abort mid-word with next word prefetched, shift coincident with cs drop
    push(32'h11223344);
    push(32'h55667788);
    begin_xfer(1'b1);
    dummy_phase();
    check("abort_first", 32'(io), 32'h1);
    shift_pulse();
    check("abort_n1", 32'(io), 32'h1);
    shift_pulse();
    check("abort_n2", 32'(io), 32'h2);
    shift_pulse();
    check("abort_n3", 32'(io), 32'h2);
    shift = 1'b1;
    cs    = 1'b0;
    step();
    shift = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_oe", 32'(io_oe), 32'd0);

    // Restart consumes the prefetched word; start during SHIFT is ignored
    w1 = 32'h55667788;
    begin_xfer(1'b0);
    dummy_phase();
    check("restart_first", 32'(io), 32'h5);
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_start_io", 32'(io), 32'h5);
    check("restart_start_oe", 32'(io_oe), 32'd1);
    for (int k = 1; k < 8; k++) begin
      shift_pulse();
      exp_nib = w1[31-4*k -: 4];
      check("restart_nib", 32'(io), 32'(exp_nib));
    end
    check("restart_underrun", 32'(underrun), 32'd0);
    drop_cs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
